// File: rtl/cnn_pkg.sv
// Constants and types shared by the conv post-processing blocks.
// Widths here must agree with the requant stage.
package cnn_pkg;

    localparam int CNN_DATA_WIDTH  = 32;
    localparam int CNN_BIAS_WIDTH  = 32;
    localparam int CNN_SCALE_WIDTH = 16;

    // Unsigned Q8.8 fixed-point scale factor.
    typedef logic [CNN_SCALE_WIDTH-1:0] q8_8_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bsr_state_t;

endpackage

// File: rtl/bsr_param_table.sv
// Per-channel bias/scale register file: one write port, one asynchronous read port.
// Latency: write lands on the next clk edge; read is combinational.
// Backpressure: none; out-of-range addresses are dropped on write and read back as zero.
module bsr_param_table
    import cnn_pkg::*;
#(
    parameter int NUM_CH      = 16,
    parameter int CH_W        = 4,
    parameter int BIAS_WIDTH  = CNN_BIAS_WIDTH,
    parameter int SCALE_WIDTH = CNN_SCALE_WIDTH
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [CH_W-1:0]        waddr,
    input  logic [BIAS_WIDTH-1:0]  wbias,
    input  logic [SCALE_WIDTH-1:0] wscale,
    input  logic [CH_W-1:0]        raddr,
    output logic [BIAS_WIDTH-1:0]  rbias,
    output logic [SCALE_WIDTH-1:0] rscale
);

    logic [BIAS_WIDTH-1:0]  bias_mem  [NUM_CH];
    logic [SCALE_WIDTH-1:0] scale_mem [NUM_CH];

    // Table contents are deliberately not reset; software reloads them per network.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < NUM_CH)) begin
            bias_mem[waddr]  <= wbias;
            scale_mem[waddr] <= wscale;
        end
    end

    always_comb begin
        rbias  = '0;
        rscale = '0;
        if (32'(raddr) < NUM_CH) begin
            rbias  = bias_mem[raddr];
            rscale = scale_mem[raddr];
        end
    end

endmodule

// File: rtl/bsr_sequencer.sv
// Tags the channel-major accumulator stream with per-channel bias/scale for requant.
// Latency: 1 cycle from input transfer to brs_valid; done is 1 cycle after leaving DRAIN.
// Backpressure: single output register, no skid; acc_ready = !brs_valid || brs_ready in RUN.
// Optional stall counter port enabled by defining BSR_SEQUENCER_PERF_EN.
module bsr_sequencer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = CNN_DATA_WIDTH,
    parameter int BIAS_WIDTH  = CNN_BIAS_WIDTH,
    parameter int SCALE_WIDTH = CNN_SCALE_WIDTH,
    parameter int NUM_CH      = 16,
    parameter int CH_W        = $clog2(NUM_CH),
    parameter int PIX_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [CH_W-1:0]        cfg_addr,
    input  logic [BIAS_WIDTH-1:0]  cfg_bias,
    input  logic [SCALE_WIDTH-1:0] cfg_scale,
    input  logic                   start,
    input  logic [CH_W:0]          num_ch,
    input  logic [PIX_W-1:0]       pix_per_ch,
    input  logic                   acc_valid,
    output logic                   acc_ready,
    input  logic [DATA_WIDTH-1:0]  acc_data,
    output logic                   brs_valid,
    input  logic                   brs_ready,
    output logic [DATA_WIDTH-1:0]  brs_data,
    output logic [BIAS_WIDTH-1:0]  brs_bias,
    output logic [SCALE_WIDTH-1:0] brs_scale,
    output logic [CH_W-1:0]        ch_idx,
    output logic                   busy,
    output logic                   done
`ifdef BSR_SEQUENCER_PERF_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    bsr_state_t             state, state_nxt;
    logic [CH_W:0]          num_ch_q;
    logic [PIX_W-1:0]       pix_q;
    logic [PIX_W-1:0]       pix_cnt;
    logic                   in_xfer, out_xfer;
    logic                   pix_last, last_word, cfg_bad, start_ok;
    logic [BIAS_WIDTH-1:0]  tbl_bias;
    logic [SCALE_WIDTH-1:0] tbl_scale;

    assign in_xfer   = acc_valid && acc_ready;
    assign out_xfer  = brs_valid && brs_ready;
    assign start_ok  = start && (state == ST_IDLE);
    assign pix_last  = (pix_cnt == pix_q - PIX_W'(1));
    assign last_word = pix_last && ({1'b0, ch_idx} == num_ch_q - (CH_W+1)'(1));
    assign cfg_bad   = (num_ch == '0) || (32'(num_ch) > NUM_CH) || (pix_per_ch == '0);

    bsr_param_table #(
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W),
        .BIAS_WIDTH  (BIAS_WIDTH),
        .SCALE_WIDTH (SCALE_WIDTH)
    ) u_table (
        .clk    (clk),
        .we     (cfg_we && (state == ST_IDLE)),
        .waddr  (cfg_addr),
        .wbias  (cfg_bias),
        .wscale (cfg_scale),
        .raddr  (ch_idx),
        .rbias  (tbl_bias),
        .rscale (tbl_scale)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = cfg_bad ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                busy      = 1'b1;
                acc_ready = !brs_valid || brs_ready;
                if (in_xfer && last_word) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!brs_valid || out_xfer) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_ch_q <= '0;
            pix_q    <= '0;
            pix_cnt  <= '0;
            ch_idx   <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            if (start_ok) begin
                num_ch_q <= num_ch;
                pix_q    <= pix_per_ch;
                pix_cnt  <= '0;
                ch_idx   <= '0;
            end else if (in_xfer) begin
                if (pix_last) begin
                    pix_cnt <= '0;
                    ch_idx  <= ch_idx + CH_W'(1);
                end else begin
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end
            end
        end
    end

    // A new word may replace the current one in the same cycle it leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brs_valid <= 1'b0;
            brs_data  <= '0;
            brs_bias  <= '0;
            brs_scale <= '0;
        end else if (in_xfer) begin
            brs_valid <= 1'b1;
            brs_data  <= acc_data;
            brs_bias  <= tbl_bias;
            brs_scale <= tbl_scale;
        end else if (out_xfer) begin
            brs_valid <= 1'b0;
        end
    end

`ifdef BSR_SEQUENCER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (busy && brs_valid && !brs_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bsr_sequencer.sv
// Self-checking bench for bsr_sequencer: vector table, directed corner cases, random layers.
// Expected words come from a channel-major table model; timing from the done/DRAIN rule.
module tb_bsr_sequencer;

    localparam int DW  = 32;
    localparam int BW  = 32;
    localparam int SW  = 16;
    localparam int NCH = 16;
    localparam int CHW = 4;
    localparam int PW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [CHW-1:0] cfg_addr = '0;
    logic [BW-1:0] cfg_bias = '0;
    logic [SW-1:0] cfg_scale = '0;
    logic          start = 1'b0;
    logic [CHW:0]  num_ch = '0;
    logic [PW-1:0] pix_per_ch = '0;
    logic          acc_valid = 1'b0;
    logic          acc_ready;
    logic [DW-1:0] acc_data = '0;
    logic          brs_valid;
    logic          brs_ready = 1'b1;
    logic [DW-1:0] brs_data;
    logic [BW-1:0] brs_bias;
    logic [SW-1:0] brs_scale;
    logic [CHW-1:0] ch_idx;
    logic          busy;
    logic          done;
`ifdef BSR_SEQUENCER_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    bsr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_bias   (cfg_bias),
        .cfg_scale  (cfg_scale),
        .start      (start),
        .num_ch     (num_ch),
        .pix_per_ch (pix_per_ch),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_data   (acc_data),
        .brs_valid  (brs_valid),
        .brs_ready  (brs_ready),
        .brs_data   (brs_data),
        .brs_bias   (brs_bias),
        .brs_scale  (brs_scale),
        .ch_idx     (ch_idx),
        .busy       (busy),
        .done       (done)
`ifdef BSR_SEQUENCER_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference table: only writes issued while the block is idle land here.
    logic [BW-1:0] m_bias  [NCH];
    logic [SW-1:0] m_scale [NCH];

    typedef struct {
        int nch;
        int ppc;
        int vld_pct;
        int rdy_pct;
        bit mid_write;
        bit extra_start;
        bit stall4;
        int exp_words;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int words_for(input int nch, input int ppc);
        if (nch < 1 || nch > NCH || ppc < 1) return 0;
        return nch * ppc;
    endfunction

    task automatic cfg_write(input int a, input logic [BW-1:0] b, input logic [SW-1:0] s);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = CHW'(a);
        cfg_bias = b;
        cfg_scale = s;
        @(negedge clk);
        cfg_we = 1'b0;
        if (a < NCH) begin
            m_bias[a]  = b;
            m_scale[a] = s;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_acc_ready"}, 64'(acc_ready), 64'd0);
        check({tag, "_brs_valid"}, 64'(brs_valid), 64'd0);
        check({tag, "_brs_data"},  64'(brs_data),  64'd0);
        check({tag, "_brs_bias"},  64'(brs_bias),  64'd0);
        check({tag, "_brs_scale"}, 64'(brs_scale), 64'd0);
        check({tag, "_ch_idx"},    64'(ch_idx),    64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
`ifdef BSR_SEQUENCER_PERF_EN
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
    endtask

    task automatic run_layer(input vec_t v, input bit rnd_data, input string tag);
        logic [DW-1:0] vals[$];
        logic [DW-1:0] pd;
        logic [BW-1:0] pb;
        logic [SW-1:0] ps;
        int total, budget, c, exp_done;
        int sent = 0, got = 0, extra = 0, done_n = 0, done_c = -1, last_out_c = 0;
        int stall_obs = 0, stall_left = 0;
        bit stalled = 0, wrote = 0, hold = 0, busy_seen = 0, restarted = 0;
        total = v.exp_words;
        for (int k = 0; k < total; k++) vals.push_back(rnd_data ? $urandom : DW'(k + 1));
        pd = '0; pb = '0; ps = '0;
        @(negedge clk);
        start = 1'b1;
        num_ch = (CHW+1)'(v.nch);
        pix_per_ch = PW'(v.ppc);
        acc_valid = 1'b0;
        brs_ready = 1'b1;
        budget = total * 20 + 40;
        c = 0;
        while (c < budget && !(done_n > 0 && c >= done_c + 3)) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (v.extra_start && sent == 2 && !restarted) begin
                restarted = 1;
                start = 1'b1;
                num_ch = 5'd1;
                pix_per_ch = 16'd1;
            end
            cfg_we = 1'b0;
            if (v.mid_write && sent == 1 && !wrote) begin
                wrote = 1;
                cfg_we = 1'b1;
                cfg_addr = '0;
                cfg_bias = 32'd99;
                cfg_scale = 16'h0300;
            end
            if (v.stall4 && got == 2 && !stalled) begin
                stalled = 1;
                stall_left = 4;
            end
            if (stall_left > 0) begin
                brs_ready = 1'b0;
                stall_left--;
            end else begin
                brs_ready = ($urandom_range(99) < 32'(v.rdy_pct));
            end
            acc_valid = ($urandom_range(99) < 32'(v.vld_pct));
            acc_data = (sent < total) ? vals[sent] : (32'hBAD0_0000 + 32'(sent));
            #1;
            if (hold) begin
                check({tag, "_hold_valid"}, 64'(brs_valid), 64'd1);
                check({tag, "_hold_data"},  64'(brs_data),  64'(pd));
                check({tag, "_hold_bias"},  64'(brs_bias),  64'(pb));
                check({tag, "_hold_scale"}, 64'(brs_scale), 64'(ps));
            end
            if (brs_valid && !brs_ready) check({tag, "_no_skid"}, 64'(acc_ready), 64'd0);
            if (busy) busy_seen = 1;
            if (busy && brs_valid && !brs_ready) stall_obs++;
            if (done) begin
                done_n++;
                if (done_n == 1) done_c = c;
            end
            if (brs_valid && brs_ready) begin
                if (got < total) begin
                    check({tag, "_data"},  64'(brs_data),  64'(vals[got]));
                    check({tag, "_bias"},  64'(brs_bias),  64'(m_bias[got / v.ppc]));
                    check({tag, "_scale"}, 64'(brs_scale), 64'(m_scale[got / v.ppc]));
                end
                got++;
                last_out_c = c;
            end
            if (acc_valid && acc_ready) begin
                if (sent < total) begin
                    check({tag, "_ch_idx"}, 64'(ch_idx), 64'(sent / v.ppc));
                    sent++;
                end else begin
                    extra++;
                end
            end
            hold = brs_valid && !brs_ready;
            pd = brs_data;
            pb = brs_bias;
            ps = brs_scale;
        end
        start = 1'b0;
        cfg_we = 1'b0;
        acc_valid = 1'b0;
        brs_ready = 1'b1;
        exp_done = (total == 0) ? 2 : last_out_c + 2;
        check({tag, "_words"},      64'(got),    64'(total));
        check({tag, "_extra_acc"},  64'(extra),  64'd0);
        check({tag, "_done_count"}, 64'(done_n), 64'd1);
        check({tag, "_done_time"},  64'(done_c), 64'(exp_done));
        if (total == 0) check({tag, "_busy_seen"}, 64'(busy_seen), 64'd0);
`ifdef BSR_SEQUENCER_PERF_EN
        check({tag, "_stall_cnt"}, 64'(stall_cnt), v.stall4 ? 64'd4 : 64'(stall_obs));
`endif
    endtask

    initial begin
        vec_t vecs[9];
        vec_t rv;
        vecs[0] = '{2,  3, 100, 100, 0, 0, 0, 6};
        vecs[1] = '{2,  3, 100, 100, 0, 0, 1, 6};
        vecs[2] = '{2,  3, 100, 100, 0, 1, 0, 6};
        vecs[3] = '{2,  3, 100, 100, 1, 0, 0, 6};
        vecs[4] = '{2,  0, 100, 100, 0, 0, 0, 0};
        vecs[5] = '{0,  4, 100, 100, 0, 0, 0, 0};
        vecs[6] = '{17, 2, 100, 100, 0, 0, 0, 0};
        vecs[7] = '{16, 2,  60,  70, 0, 0, 0, 32};
        vecs[8] = '{1,  1, 100, 100, 0, 0, 0, 1};

        for (int i = 0; i < NCH; i++) begin
            m_bias[i]  = '0;
            m_scale[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) cfg_write(i, BW'(i * 3), SW'(16'h0080 + i));
        cfg_write(0, 32'd10, 16'h0100);
        cfg_write(1, 32'hFFFF_FFFB, 16'h0200);

        for (int i = 0; i < 9; i++) begin
            run_layer(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // The write attempted during vec3 must not have landed; this one must.
        cfg_write(0, 32'd99, 16'h0100);
        run_layer('{1, 2, 100, 100, 0, 0, 0, 2}, 1'b0, "after_write");

        // Asynchronous reset with a word parked in the output register.
        @(negedge clk);
        start = 1'b1; num_ch = 5'd2; pix_per_ch = 16'd3; acc_valid = 1'b0; brs_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; acc_valid = 1'b1; acc_data = 32'd1;
        @(negedge clk);
        acc_data = 32'd2;
        @(negedge clk);
        acc_data = 32'd3;
        @(negedge clk);
        acc_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_layer('{1, 1, 100, 100, 0, 0, 0, 1}, 1'b0, "post_reset");

        for (int i = 0; i < NCH; i++) cfg_write(i, $urandom, SW'($urandom));
        for (int t = 0; t < 12; t++) begin
            rv.nch = $urandom_range(16, 1);
            rv.ppc = $urandom_range(6, 1);
            if (t == 5) rv.ppc = 0;
            rv.vld_pct = $urandom_range(100, 30);
            rv.rdy_pct = $urandom_range(100, 30);
            rv.mid_write = 1'b0;
            rv.extra_start = 1'b0;
            rv.stall4 = 1'b0;
            rv.exp_words = words_for(rv.nch, rv.ppc);
            run_layer(rv, 1'b1, $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
